// File: rtl/ram_arb_nport.sv
// N-port arbiter in front of one single-ported SRAM bank (req/gnt/rvalid protocol).
// One transaction outstanding; grant and RAM strobe are combinational from the winner.
`timescale 1ns/1ps

module ram_arb_nport #(
  parameter int NUM_PORTS  = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ARB_MODE   = 0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_PORTS-1:0]            port_req_i,
  output logic [NUM_PORTS-1:0]            port_gnt_o,
  output logic [NUM_PORTS-1:0]            port_rvalid_o,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] port_addr_i,
  input  logic [NUM_PORTS-1:0]            port_we_i,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] port_be_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] port_wdata_i,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] port_rdata_o,
  output logic                            ram_en_o,
  output logic [ADDR_WIDTH-1:0]           ram_addr_o,
  output logic                            ram_we_o,
  output logic [DATA_WIDTH/8-1:0]         ram_be_o,
  output logic [DATA_WIDTH-1:0]           ram_wdata_o,
  input  logic [DATA_WIDTH-1:0]           ram_rdata_i,
  input  logic                            ram_rvalid_i,
  output logic                            busy_o,
  output logic                            err_rvalid_o
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  localparam logic IDLE = 1'b0;
  localparam logic BUSY = 1'b1;

  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_PORTS - 1);

  logic             state_q;
  logic [IDX_W-1:0] owner_q;
  logic [IDX_W-1:0] last_q;
  logic [IDX_W-1:0] winner;
  logic             any_req;
  logic             grant_ok;
  logic             do_grant;

  assign any_req  = |port_req_i;
  assign grant_ok = (state_q == IDLE) || ram_rvalid_i;
  // Qualified with rst_n so nothing is granted or strobed while reset is held.
  assign do_grant = rst_n && grant_ok && any_req;

  // Round-robin searches from last_q+1 and wraps; fixed priority searches from 0.
  always_comb begin : arbitrate
    int               idx;
    logic [IDX_W-1:0] idx_w;
    logic             found;
    // NOTE: every variable gets a default first so no path can infer a latch.
    idx    = 0;
    idx_w  = '0;
    found  = 1'b0;
    winner = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (ARB_MODE == 0) idx = i;
      else               idx = (int'(last_q) + 1 + i) % NUM_PORTS;
      idx_w = idx[IDX_W-1:0];
      if (!found && port_req_i[idx_w]) begin
        winner = idx_w;
        found  = 1'b1;
      end
    end
  end

  always_comb begin : request_mux
    port_gnt_o  = '0;
    ram_en_o    = 1'b0;
    ram_addr_o  = '0;
    ram_we_o    = 1'b0;
    ram_be_o    = '0;
    ram_wdata_o = '0;
    if (do_grant) begin
      port_gnt_o[winner] = 1'b1;
      ram_en_o           = 1'b1;
      ram_addr_o         = port_addr_i[winner*ADDR_WIDTH +: ADDR_WIDTH];
      ram_we_o           = port_we_i[winner];
      ram_be_o           = port_be_i[winner*BE_W +: BE_W];
      ram_wdata_o        = port_wdata_i[winner*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // The response belongs to owner_q even when a new grant goes out in the same cycle.
  always_comb begin : response_route
    port_rvalid_o = '0;
    port_rdata_o  = '0;
    if (state_q == BUSY) begin
      port_rvalid_o[owner_q]                          = ram_rvalid_i;
      port_rdata_o[owner_q*DATA_WIDTH +: DATA_WIDTH] = ram_rdata_i;
    end
  end

  assign busy_o       = (state_q == BUSY);
  assign err_rvalid_o = rst_n && (state_q == IDLE) && ram_rvalid_i;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= LAST_RST;
    end else if (grant_ok) begin
      if (any_req) begin
        state_q <= BUSY;
        owner_q <= winner;
        last_q  <= winner;
      end else begin
        state_q <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_ram_arb_nport.sv
// Bench for ram_arb_nport: fixed-priority and round-robin instances share stimulus and
// are compared every cycle against a transaction-level model, plus literal directed checks.
`timescale 1ns/1ps

module tb_ram_arb_nport;

  localparam int NP = 4;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic clk = 1'b0;
  logic rst_n;

  logic [NP-1:0]    req;
  logic [NP-1:0]    we;
  logic [NP*AW-1:0] addr;
  logic [NP*BW-1:0] be;
  logic [NP*DW-1:0] wdata;
  logic [DW-1:0]    rdata;
  logic             rvalid;

  logic [NP-1:0] gnt_f, rv_f, gnt_r, rv_r;
  logic [NP*DW-1:0] rd_f, rd_r;
  logic en_f, we_f, busy_f, err_f, en_r, we_r, busy_r, err_r;
  logic [AW-1:0] ra_f, ra_r;
  logic [BW-1:0] rbe_f, rbe_r;
  logic [DW-1:0] rwd_f, rwd_r;

  int total = 0;
  int bad   = 0;

  bit m_busy[2]  = '{0, 0};
  int m_owner[2] = '{0, 0};
  int m_last[2]  = '{NP-1, NP-1};

  always #5 clk = ~clk;

  ram_arb_nport #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ARB_MODE(0)) u_fp (
    .clk(clk), .rst_n(rst_n),
    .port_req_i(req), .port_gnt_o(gnt_f), .port_rvalid_o(rv_f),
    .port_addr_i(addr), .port_we_i(we), .port_be_i(be), .port_wdata_i(wdata),
    .port_rdata_o(rd_f),
    .ram_en_o(en_f), .ram_addr_o(ra_f), .ram_we_o(we_f), .ram_be_o(rbe_f),
    .ram_wdata_o(rwd_f), .ram_rdata_i(rdata), .ram_rvalid_i(rvalid),
    .busy_o(busy_f), .err_rvalid_o(err_f)
  );

  ram_arb_nport #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ARB_MODE(1)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .port_req_i(req), .port_gnt_o(gnt_r), .port_rvalid_o(rv_r),
    .port_addr_i(addr), .port_we_i(we), .port_be_i(be), .port_wdata_i(wdata),
    .port_rdata_o(rd_r),
    .ram_en_o(en_r), .ram_addr_o(ra_r), .ram_we_o(we_r), .ram_be_o(rbe_r),
    .ram_wdata_o(rwd_r), .ram_rdata_i(rdata), .ram_rvalid_i(rvalid),
    .busy_o(busy_r), .err_rvalid_o(err_r)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Winner by rule: lowest requester, or first requester after the last winner.
  function automatic int pick(input int mode, input logic [NP-1:0] r, input int last);
    if (mode == 0) begin
      for (int i = 0; i < NP; i++) if (r[i]) return i;
    end else begin
      for (int k = 1; k <= NP; k++) begin
        int i;
        i = (last + k) % NP;
        if (r[i]) return i;
      end
    end
    return -1;
  endfunction

  task automatic model_step(input int m);
    logic [NP-1:0] a_gnt, a_rv, e_gnt, e_rv;
    logic a_en, a_we, a_busy, a_err, e_en, e_we, e_busy, e_err;
    logic [AW-1:0] a_addr, e_addr;
    logic [BW-1:0] a_be, e_be;
    logic [DW-1:0] a_wd, e_wd;
    logic [NP*DW-1:0] a_rd, e_rd;
    bit elig;
    int w;
    if (m == 0) begin
      a_gnt = gnt_f; a_rv = rv_f; a_en = en_f; a_we = we_f; a_busy = busy_f; a_err = err_f;
      a_addr = ra_f; a_be = rbe_f; a_wd = rwd_f; a_rd = rd_f;
    end else begin
      a_gnt = gnt_r; a_rv = rv_r; a_en = en_r; a_we = we_r; a_busy = busy_r; a_err = err_r;
      a_addr = ra_r; a_be = rbe_r; a_wd = rwd_r; a_rd = rd_r;
    end
    e_gnt = '0; e_rv = '0; e_en = 0; e_we = 0; e_busy = 0; e_err = 0;
    e_addr = '0; e_be = '0; e_wd = '0; e_rd = '0;
    elig = 0;
    w = -1;
    if (rst_n) begin
      elig = !m_busy[m] || rvalid;
      w = pick(m, req, m_last[m]);
      if (elig && w >= 0) begin
        e_gnt[w] = 1'b1;
        e_en     = 1'b1;
        e_addr   = addr[w*AW +: AW];
        e_we     = we[w];
        e_be     = be[w*BW +: BW];
        e_wd     = wdata[w*DW +: DW];
      end
      if (m_busy[m]) begin
        e_rv[m_owner[m]]          = rvalid;
        e_rd[m_owner[m]*DW +: DW] = rdata;
      end
      e_err  = !m_busy[m] && rvalid;
      e_busy = m_busy[m];
    end
    check($sformatf("m%0d gnt", m), a_gnt, e_gnt);
    check($sformatf("m%0d rvalid", m), a_rv, e_rv);
    check($sformatf("m%0d rdata", m), a_rd, e_rd);
    check($sformatf("m%0d ram_en", m), a_en, e_en);
    check($sformatf("m%0d ram_addr", m), a_addr, e_addr);
    check($sformatf("m%0d ram_we", m), a_we, e_we);
    check($sformatf("m%0d ram_be", m), a_be, e_be);
    check($sformatf("m%0d ram_wdata", m), a_wd, e_wd);
    check($sformatf("m%0d busy", m), a_busy, e_busy);
    check($sformatf("m%0d err", m), a_err, e_err);
    if (!rst_n) begin
      m_busy[m] = 0; m_owner[m] = 0; m_last[m] = NP - 1;
    end else if (elig) begin
      if (w >= 0) begin
        m_busy[m] = 1; m_owner[m] = w; m_last[m] = w;
      end else begin
        m_busy[m] = 0;
      end
    end
  endtask

  always @(negedge clk) begin
    model_step(0);
    model_step(1);
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [NP-1:0] exp_v;
    bit pending;
    int rem;
    logic en_seen;

    rst_n = 1'b0; req = '0; we = '0; be = '1; rdata = '0; rvalid = 1'b0;
    addr = {$urandom, $urandom}; wdata = {$urandom, $urandom, $urandom, $urandom};

    // Reset held with every port requesting: all outputs quiet.
    req = 4'hF;
    addr[0*AW +: AW] = 16'h1000;
    @(negedge clk);
    check("rst gnt_f", gnt_f, 4'b0000);
    check("rst gnt_r", gnt_r, 4'b0000);
    check("rst en", en_f, 1'b0);
    check("rst busy", busy_f, 1'b0);
    check("rst rvalid", rv_f, 4'b0000);
    check("rst rdata", rd_f, 128'h0);
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    check("rel gnt_f", gnt_f, 4'b0001);
    check("rel gnt_r", gnt_r, 4'b0001);
    check("rel en", en_f, 1'b1);
    check("rel addr", ra_f, 16'h1000);

    // Fixed priority with 1-cycle RAM: port 1 always beats port 3.
    for (int k = 0; k < 6; k++) begin
      next_cycle();
      req = 4'b1010; rvalid = 1'b1; rdata = $urandom;
      @(negedge clk);
      check("fp gnt", gnt_f, 4'b0010);
      check("fp en", en_f, 1'b1);
    end
    next_cycle();
    req = '0; rvalid = 1'b1;
    @(negedge clk);
    check("fp drain rvalid", rv_f, 4'b0010);
    next_cycle();
    rvalid = 1'b0;
    @(negedge clk);
    check("fp idle busy", busy_f, 1'b0);

    // Round-robin fairness from a fresh reset.
    next_cycle();
    rst_n = 1'b0;
    @(negedge clk);
    next_cycle();
    rst_n = 1'b1; req = 4'hF; rvalid = 1'b0;
    @(negedge clk);
    check("rr gnt 0", gnt_r, 4'b0001);
    for (int k = 1; k < 8; k++) begin
      next_cycle();
      rvalid = 1'b1; rdata = $urandom;
      @(negedge clk);
      exp_v = 4'b0001 << (k % 4);
      check($sformatf("rr gnt %0d", k), gnt_r, exp_v);
      exp_v = 4'b0001 << ((k - 1) % 4);
      check($sformatf("rr rvalid %0d", k), rv_r, exp_v);
    end
    next_cycle();
    req = '0; rvalid = 1'b1;
    @(negedge clk);
    check("rr last rvalid", rv_r, 4'b1000);
    next_cycle();
    rvalid = 1'b0;

    // Three-cycle RAM latency, port 2 read of 0x100.
    next_cycle();
    req = 4'b0100; we = '0; addr[2*AW +: AW] = 16'h0100;
    @(negedge clk);
    check("lat gnt", gnt_f, 4'b0100);
    check("lat en", en_f, 1'b1);
    check("lat addr", ra_f, 16'h0100);
    for (int c = 1; c <= 3; c++) begin
      next_cycle();
      req = '0; rvalid = (c == 3);
      rdata = (c == 3) ? 32'hDEADBEEF : $urandom;
      @(negedge clk);
      check($sformatf("lat en %0d", c), en_f, 1'b0);
      check($sformatf("lat busy %0d", c), busy_f, 1'b1);
    end
    check("lat rdata", rd_f, {32'h0, 32'hDEADBEEF, 32'h0, 32'h0});
    check("lat rvalid", rv_f, 4'b0100);
    next_cycle();
    rvalid = 1'b0;
    @(negedge clk);
    check("lat done busy", busy_f, 1'b0);

    // Back-to-back handover: port 0 write completes while port 3 requests.
    next_cycle();
    req = 4'b0001; we = 4'b0001; addr[0*AW +: AW] = 16'h0040;
    @(negedge clk);
    check("b2b gnt0", gnt_f, 4'b0001);
    next_cycle();
    req = 4'b1000; we = 4'b0000; addr[3*AW +: AW] = 16'h00C0; rvalid = 1'b1;
    @(negedge clk);
    check("b2b rvalid_f", rv_f, 4'b0001);
    check("b2b gnt_f", gnt_f, 4'b1000);
    check("b2b rvalid_r", rv_r, 4'b0001);
    check("b2b gnt_r", gnt_r, 4'b1000);
    check("b2b addr", ra_f, 16'h00C0);
    check("b2b we", we_f, 1'b0);
    next_cycle();
    req = '0; rvalid = 1'b1;
    @(negedge clk);
    check("b2b rvalid3", rv_f, 4'b1000);
    next_cycle();
    rvalid = 1'b0;

    // Spurious response in IDLE, then again after a reset mid-transaction.
    next_cycle();
    rvalid = 1'b1;
    @(negedge clk);
    check("spur err_f", err_f, 1'b1);
    check("spur err_r", err_r, 1'b1);
    check("spur rvalid", rv_f, 4'b0000);
    next_cycle();
    rvalid = 1'b0;
    @(negedge clk);
    check("spur err clear", err_f, 1'b0);
    next_cycle();
    req = 4'b0010;
    @(negedge clk);
    check("mid gnt", gnt_f, 4'b0010);
    next_cycle();
    req = '0; rst_n = 1'b0;
    @(negedge clk);
    check("mid rst busy", busy_f, 1'b0);
    next_cycle();
    rst_n = 1'b1; rvalid = 1'b1;
    @(negedge clk);
    check("mid spur err", err_f, 1'b1);
    check("mid spur rvalid_f", rv_f, 4'b0000);
    check("mid spur rvalid_r", rv_r, 4'b0000);
    next_cycle();
    rvalid = 1'b0;

    // Randomized traffic with a RAM responder of 1..3 cycle latency.
    pending = 0;
    rem = 0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      en_seen = en_f;
      next_cycle();
      rst_n = ($urandom_range(0, 199) != 0);
      req   = 4'($urandom);
      we    = 4'($urandom);
      be    = 16'($urandom);
      addr  = {$urandom, $urandom};
      wdata = {$urandom, $urandom, $urandom, $urandom};
      rdata = $urandom;
      if (en_seen) begin
        pending = 1;
        rem = $urandom_range(1, 3);
      end
      if (pending) begin
        rem--;
        rvalid = (rem == 0);
        if (rem == 0) pending = 0;
      end else begin
        rvalid = ($urandom_range(0, 15) == 0);
      end
    end
    next_cycle();
    rst_n = 1'b1; req = '0; rvalid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_arb_nport.md
# ram_arb_nport

Parametrised N-port arbiter between requesting masters (core data ports, AXI/APB bridges, debug) and one single-ported SRAM bank with a req/gnt/rvalid protocol. Generalises the two-port priority RAM mux to NUM_PORTS channels with a selectable fixed-priority or round-robin policy. One transaction is outstanding at a time. The RAM response is steered back only to the owning port, and back-to-back grants happen in the response cycle.

## Interface
- NUM_PORTS, 4: number of requesting ports; legal range 2..8.
- ADDR_WIDTH, 32: address width.
- DATA_WIDTH, 32: data width; must be a multiple of 8. BE_W = DATA_WIDTH/8.
- ARB_MODE, 0: 0 = fixed priority (lowest index wins); 1 = round-robin.

Ports:
- clk  in  1  clock; everything is sampled on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- port_req_i  in  NUM_PORTS  per-port request.
- port_gnt_o  out  NUM_PORTS  per-port grant; one-hot or zero.
- port_rvalid_o  out  NUM_PORTS  per-port response valid; one-hot or zero.
- port_addr_i  in  NUM_PORTS×ADDR_WIDTH  packed per-port address.
- port_we_i  in  NUM_PORTS  per-port write enable.
- port_be_i  in  NUM_PORTS×BE_W  per-port byte enables.
- port_wdata_i  in  NUM_PORTS×DATA_WIDTH  per-port write data.
- port_rdata_o  out  NUM_PORTS×DATA_WIDTH  per-port read data; zero for any port that is not the owner.
- ram_en_o  out  1  RAM request strobe.
- ram_addr_o  out  ADDR_WIDTH  RAM address.
- ram_we_o  out  1  RAM write enable.
- ram_be_o  out  BE_W  RAM byte enables.
- ram_wdata_o  out  DATA_WIDTH  RAM write data.
- ram_rdata_i  in  DATA_WIDTH  RAM read data.
- ram_rvalid_i  in  1  RAM response valid; asserted for both reads and writes, at least 1 cycle after ram_en_o.
- busy_o  out  1  a transaction is outstanding.
- err_rvalid_o  out  1  one-cycle pulse when ram_rvalid_i arrives with nothing outstanding.

## Operation
- **States:**
  - IDLE: nothing outstanding.
  - BUSY: one transaction outstanding; the owner index is held in owner_q.
- **Grant-eligible cycle:** state is IDLE, or state is BUSY and ram_rvalid_i=1.
- **In a grant-eligible cycle with any port_req_i set:**
  - The arbiter picks winner w.
  - port_gnt_o[w]=1 combinationally in the same cycle.
  - ram_en_o=1 and ram_addr/we/be/wdata_o are driven from port w in that same cycle.
  - Next state is BUSY with owner_q=w.
- **Without any request in that cycle:** next state is IDLE, ram_en_o=0, and the ram_* buses are 0.
- **In BUSY without ram_rvalid_i:** ram_en_o=0, the ram_* buses are 0, and no grant is issued. Requests wait; they are never dropped.
- **Response routing:**
  - While BUSY, port_rdata_o[owner_q] = ram_rdata_i.
  - port_rvalid_o[owner_q] = ram_rvalid_i.
  - All other rdata and rvalid outputs are 0.
- **Fixed priority (ARB_MODE=0):** the lowest set index of port_req_i wins.
- **Round-robin (ARB_MODE=1):**
  - Pointer last_q holds the index of the last winner; reset value is NUM_PORTS-1, so port 0 has first priority.
  - The search starts at (last_q+1) mod NUM_PORTS and wraps around.
  - last_q is updated only on a grant.
- **Same-port back-to-back:** when the owner re-requests in its response cycle, it is eligible again.
  - Under round-robin it wins only if no other port requests.
  - Under fixed priority it wins if it has the lowest index among requesters.
- **Spurious response:** ram_rvalid_i in IDLE is ignored for routing. It pulses err_rvalid_o for that cycle, and a grant may still be issued in that cycle.
- **busy_o** equals (state==BUSY).

## Timing
- **Reset values (asynchronous, immediate):**
  - state=IDLE, owner_q=0, last_q=NUM_PORTS-1.
  - All outputs are 0, including ram_en_o.
- **Latency:** request to grant and RAM strobe is 0 cycles in IDLE. Response to port_rvalid_o is 0 cycles (combinational pass-through).
- **Throughput:** with single-cycle RAM latency, one transaction per cycle is sustained.
- **Simultaneous events:** in a cycle where ram_rvalid_i=1 and a new grant is issued:
  - rvalid and rdata go to the old owner.
  - The grant and RAM strobe go to the new winner.
  - owner_q switches at the clock edge.
- **Reset mid-transaction:** the outstanding response is discarded. A ram_rvalid_i arriving after reset is treated as spurious.
- **Input stability:** ports must hold addr/we/be/wdata stable only during their grant cycle. The block registers no payload.

## Test plan
- **Reset check:** hold rst_n=0 with all req=1 → all outputs 0. Release rst_n → in that cycle port_gnt_o=4'b0001, ram_en_o=1, ram_addr_o=port0 addr.
- **Fixed priority, 1-cycle RAM:** ARB_MODE=0, req=4'b1010 continuously → grants 4'b0010 every cycle. Port 3 is never granted while port 1 requests.
- **Round-robin fairness:** ARB_MODE=1, req=4'b1111 held for 8 transactions → grant order is 0,1,2,3,0,1,2,3. Each rvalid lands on the previous winner.
- **Multi-cycle RAM latency:** 3-cycle latency, port 2 read of addr 0x100 returning 0xDEADBEEF → ram_en_o high only in the grant cycle. busy_o=1 for 3 cycles. port_rdata_o[2]=0xDEADBEEF with rvalid[2]=1. All other ports read 0.
- **Back-to-back handover:** port 0 write completes while port 3 requests → in the rvalid cycle, rvalid[0]=1 and gnt[3]=1. ram_addr_o=port3 addr, ram_we_o=port3 we.
- **Spurious response:** inject ram_rvalid_i in IDLE → err_rvalid_o=1 for one cycle and all port_rvalid_o=0. Repeat after asserting rst_n=0 mid-transaction → the same result.
